// File: rtl/axi4lite_master_if.sv
// AXI4-Lite bus bundle between the command-driven initiator and a register-file slave.
interface axi4lite_master_if #(
    parameter int unsigned AXIS_DATA_WIDTH = 32,
    parameter int unsigned AXIS_ADDR_WIDTH = 6
);
    localparam int unsigned STRB_W = AXIS_DATA_WIDTH / 8;

    logic [AXIS_ADDR_WIDTH-1:0] M_AXI_AWADDR;
    logic [2:0]                 M_AXI_AWPROT;
    logic                       M_AXI_AWVALID;
    logic                       M_AXI_AWREADY;
    logic [AXIS_DATA_WIDTH-1:0] M_AXI_WDATA;
    logic [STRB_W-1:0]          M_AXI_WSTRB;
    logic                       M_AXI_WVALID;
    logic                       M_AXI_WREADY;
    logic [1:0]                 M_AXI_BRESP;
    logic                       M_AXI_BVALID;
    logic                       M_AXI_BREADY;
    logic [AXIS_ADDR_WIDTH-1:0] M_AXI_ARADDR;
    logic [2:0]                 M_AXI_ARPROT;
    logic                       M_AXI_ARVALID;
    logic                       M_AXI_ARREADY;
    logic [AXIS_DATA_WIDTH-1:0] M_AXI_RDATA;
    logic [1:0]                 M_AXI_RRESP;
    logic                       M_AXI_RVALID;
    logic                       M_AXI_RREADY;

    modport master (
        output M_AXI_AWADDR, M_AXI_AWPROT, M_AXI_AWVALID,
        input  M_AXI_AWREADY,
        output M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID,
        input  M_AXI_WREADY,
        input  M_AXI_BRESP, M_AXI_BVALID,
        output M_AXI_BREADY,
        output M_AXI_ARADDR, M_AXI_ARPROT, M_AXI_ARVALID,
        input  M_AXI_ARREADY,
        input  M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID,
        output M_AXI_RREADY
    );

    modport slave (
        input  M_AXI_AWADDR, M_AXI_AWPROT, M_AXI_AWVALID,
        output M_AXI_AWREADY,
        input  M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID,
        output M_AXI_WREADY,
        output M_AXI_BRESP, M_AXI_BVALID,
        input  M_AXI_BREADY,
        input  M_AXI_ARADDR, M_AXI_ARPROT, M_AXI_ARVALID,
        output M_AXI_ARREADY,
        output M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID,
        input  M_AXI_RREADY
    );
endinterface

// File: rtl/axi4lite_master.sv
// Single-outstanding AXI4-Lite initiator: one command in, one AXI transaction out, one response strobe back.
// Optional watchdog enabled by defining AXI_MASTER_TIMEOUT_EN.
module axi4lite_master #(
    parameter int unsigned AXIS_DATA_WIDTH = 32,
    parameter int unsigned AXIS_ADDR_WIDTH = 6,
    parameter int unsigned TIMEOUT_CYCLES  = 1024
) (
    input  logic                         M_AXI_ACLK,
    input  logic                         M_AXI_ARESETN,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic                         cmd_write,
    input  logic [AXIS_ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [AXIS_DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [AXIS_DATA_WIDTH/8-1:0] cmd_wstrb,
    output logic                         rsp_valid,
    output logic [AXIS_DATA_WIDTH-1:0]   rsp_rdata,
    output logic [1:0]                   rsp_resp,
    axi4lite_master_if.master            m_axi
);
    localparam int unsigned STRB_W = AXIS_DATA_WIDTH / 8;

    if (!(AXIS_DATA_WIDTH == 32 || AXIS_DATA_WIDTH == 64)) begin : g_bad_data_width
        $error("axi4lite_master: AXIS_DATA_WIDTH must be 32 or 64");
    end
    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("axi4lite_master: TIMEOUT_CYCLES must be at least 2");
    end

    typedef enum logic [2:0] {IDLE, WR, WR_RESP, RD_ADDR, RD_DATA, DONE} state_t;

    state_t                     state, state_nxt;
    logic                       awvalid_q, awvalid_nxt;
    logic                       wvalid_q, wvalid_nxt;
    logic                       bready_q, bready_nxt;
    logic                       arvalid_q, arvalid_nxt;
    logic                       rready_q, rready_nxt;
    logic [AXIS_ADDR_WIDTH-1:0] addr_q, addr_nxt;
    logic [AXIS_DATA_WIDTH-1:0] wdata_q, wdata_nxt;
    logic [STRB_W-1:0]          wstrb_q, wstrb_nxt;
    logic                       rsp_valid_q, rsp_valid_nxt;
    logic [AXIS_DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_nxt;
    logic [1:0]                 rsp_resp_q, rsp_resp_nxt;

`ifdef AXI_MASTER_TIMEOUT_EN
    localparam int unsigned TMR_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMR_W-1:0] timer_q, timer_nxt;
    logic             hs;

    // Any handshake this cycle outranks a watchdog expiry in the same cycle.
    assign hs = (awvalid_q && m_axi.M_AXI_AWREADY) || (wvalid_q && m_axi.M_AXI_WREADY)
             || (bready_q && m_axi.M_AXI_BVALID) || (arvalid_q && m_axi.M_AXI_ARREADY)
             || (rready_q && m_axi.M_AXI_RVALID);
`endif

    assign cmd_ready = (state == IDLE) && M_AXI_ARESETN;

    assign m_axi.M_AXI_AWADDR  = addr_q;
    assign m_axi.M_AXI_AWPROT  = 3'b000;
    assign m_axi.M_AXI_AWVALID = awvalid_q;
    assign m_axi.M_AXI_WDATA   = wdata_q;
    assign m_axi.M_AXI_WSTRB   = wstrb_q;
    assign m_axi.M_AXI_WVALID  = wvalid_q;
    assign m_axi.M_AXI_BREADY  = bready_q;
    assign m_axi.M_AXI_ARADDR  = addr_q;
    assign m_axi.M_AXI_ARPROT  = 3'b000;
    assign m_axi.M_AXI_ARVALID = arvalid_q;
    assign m_axi.M_AXI_RREADY  = rready_q;

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_resp  = rsp_resp_q;

    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            state       <= IDLE;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= 2'b00;
        end else begin
            state       <= state_nxt;
            awvalid_q   <= awvalid_nxt;
            wvalid_q    <= wvalid_nxt;
            bready_q    <= bready_nxt;
            arvalid_q   <= arvalid_nxt;
            rready_q    <= rready_nxt;
            addr_q      <= addr_nxt;
            wdata_q     <= wdata_nxt;
            wstrb_q     <= wstrb_nxt;
            rsp_valid_q <= rsp_valid_nxt;
            rsp_rdata_q <= rsp_rdata_nxt;
            rsp_resp_q  <= rsp_resp_nxt;
        end
    end

    // Next-state and next-output decode; every output register is loaded from here.
    always_comb begin
        state_nxt     = state;
        awvalid_nxt   = awvalid_q;
        wvalid_nxt    = wvalid_q;
        bready_nxt    = bready_q;
        arvalid_nxt   = arvalid_q;
        rready_nxt    = rready_q;
        addr_nxt      = addr_q;
        wdata_nxt     = wdata_q;
        wstrb_nxt     = wstrb_q;
        rsp_valid_nxt = 1'b0;
        rsp_rdata_nxt = rsp_rdata_q;
        rsp_resp_nxt  = rsp_resp_q;

        case (state)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    addr_nxt  = cmd_addr;
                    wdata_nxt = cmd_wdata;
                    wstrb_nxt = cmd_wstrb;
                    if (cmd_write) begin
                        state_nxt   = WR;
                        awvalid_nxt = 1'b1;
                        wvalid_nxt  = 1'b1;
                    end else begin
                        state_nxt   = RD_ADDR;
                        arvalid_nxt = 1'b1;
                    end
                end
            end
            WR: begin
                // AW and W retire independently; leave once both are gone.
                awvalid_nxt = awvalid_q && !m_axi.M_AXI_AWREADY;
                wvalid_nxt  = wvalid_q && !m_axi.M_AXI_WREADY;
                if (!awvalid_nxt && !wvalid_nxt) begin
                    state_nxt  = WR_RESP;
                    bready_nxt = 1'b1;
                end
            end
            WR_RESP: begin
                if (bready_q && m_axi.M_AXI_BVALID) begin
                    bready_nxt    = 1'b0;
                    rsp_valid_nxt = 1'b1;
                    rsp_rdata_nxt = '0;
                    rsp_resp_nxt  = m_axi.M_AXI_BRESP;
                    state_nxt     = DONE;
                end
            end
            RD_ADDR: begin
                if (m_axi.M_AXI_ARREADY) begin
                    arvalid_nxt = 1'b0;
                    rready_nxt  = 1'b1;
                    state_nxt   = RD_DATA;
                end
            end
            RD_DATA: begin
                if (rready_q && m_axi.M_AXI_RVALID) begin
                    rready_nxt    = 1'b0;
                    rsp_valid_nxt = 1'b1;
                    rsp_rdata_nxt = m_axi.M_AXI_RDATA;
                    rsp_resp_nxt  = m_axi.M_AXI_RRESP;
                    state_nxt     = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

`ifdef AXI_MASTER_TIMEOUT_EN
        if ((state inside {WR, WR_RESP, RD_ADDR, RD_DATA}) && !hs
                && (timer_q >= TMR_W'(TIMEOUT_CYCLES - 1))) begin
            awvalid_nxt   = 1'b0;
            wvalid_nxt    = 1'b0;
            bready_nxt    = 1'b0;
            arvalid_nxt   = 1'b0;
            rready_nxt    = 1'b0;
            rsp_valid_nxt = 1'b1;
            rsp_rdata_nxt = '0;
            rsp_resp_nxt  = 2'b10;
            state_nxt     = DONE;
        end
`endif
    end

`ifdef AXI_MASTER_TIMEOUT_EN
    // Watchdog restarts on every state change and idles outside the bus-waiting states.
    always_comb begin
        timer_nxt = timer_q + TMR_W'(1);
        if ((state_nxt != state) || (state == IDLE) || (state == DONE)) begin
            timer_nxt = '0;
        end
    end

    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_nxt;
        end
    end
`endif
endmodule

// File: tb/tb_axi4lite_master.sv
// Directed bench for axi4lite_master: behavioural register-file slave with programmable READY/response delays.
module tb_axi4lite_master;
    localparam int unsigned DW = 32;
    localparam int unsigned AW = 6;
`ifdef AXI_MASTER_TIMEOUT_EN
    localparam int unsigned TO = 16;
`else
    localparam int unsigned TO = 1024;
`endif

    logic          clk;
    logic          rst_n;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic [3:0]    cmd_wstrb;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic [1:0]    rsp_resp;

    axi4lite_master_if #(.AXIS_DATA_WIDTH(DW), .AXIS_ADDR_WIDTH(AW)) ifc ();

    axi4lite_master #(.AXIS_DATA_WIDTH(DW), .AXIS_ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
        .M_AXI_ACLK(clk), .M_AXI_ARESETN(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
        .m_axi(ifc.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Slave configuration, written only by the stimulus process.
    int          aw_dly, w_dly, ar_dly, r_dly;
    logic [1:0]  slv_resp;
    logic        ovr_en;
    logic [31:0] ovr_data;
    logic        spur;

    // Slave state
    logic [31:0] mem [16];
    int          aw_cnt, w_cnt, ar_cnt, r_cnt;
    logic        got_aw, got_w, b_pend, r_pend;
    logic [5:0]  aw_a;
    logic [31:0] w_d, r_d;
    logic [3:0]  w_s;
    logic        a_ok, w_ok;
    logic [5:0]  a_addr;
    logic [31:0] wd_c;
    logic [3:0]  ws_c;

    assign ifc.M_AXI_AWREADY = ifc.M_AXI_AWVALID && (aw_cnt >= aw_dly);
    assign ifc.M_AXI_WREADY  = ifc.M_AXI_WVALID && (w_cnt >= w_dly);
    assign ifc.M_AXI_ARREADY = ifc.M_AXI_ARVALID && (ar_cnt >= ar_dly);
    assign ifc.M_AXI_BVALID  = b_pend || spur;
    assign ifc.M_AXI_BRESP   = slv_resp;
    assign ifc.M_AXI_RVALID  = (r_pend && r_cnt == 0) || spur;
    assign ifc.M_AXI_RRESP   = slv_resp;
    assign ifc.M_AXI_RDATA   = r_d;

    always_comb begin
        a_ok   = got_aw || (ifc.M_AXI_AWVALID && ifc.M_AXI_AWREADY);
        w_ok   = got_w || (ifc.M_AXI_WVALID && ifc.M_AXI_WREADY);
        a_addr = got_aw ? aw_a : ifc.M_AXI_AWADDR;
        wd_c   = got_w ? w_d : ifc.M_AXI_WDATA;
        ws_c   = got_w ? w_s : ifc.M_AXI_WSTRB;
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) mem[i] <= '0;
            aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0; r_cnt <= 0;
            got_aw <= 1'b0; got_w <= 1'b0; b_pend <= 1'b0; r_pend <= 1'b0;
            aw_a <= '0; w_d <= '0; w_s <= '0; r_d <= '0;
        end else begin
            aw_cnt <= (ifc.M_AXI_AWVALID && !ifc.M_AXI_AWREADY) ? aw_cnt + 1 : 0;
            w_cnt  <= (ifc.M_AXI_WVALID && !ifc.M_AXI_WREADY) ? w_cnt + 1 : 0;
            ar_cnt <= (ifc.M_AXI_ARVALID && !ifc.M_AXI_ARREADY) ? ar_cnt + 1 : 0;
            if (a_ok && w_ok && !b_pend) begin
                for (int i = 0; i < 4; i++)
                    if (ws_c[i]) mem[a_addr[5:2]][8*i +: 8] <= wd_c[8*i +: 8];
                b_pend <= 1'b1;
                got_aw <= 1'b0;
                got_w  <= 1'b0;
            end else begin
                if (ifc.M_AXI_AWVALID && ifc.M_AXI_AWREADY) begin
                    got_aw <= 1'b1;
                    aw_a   <= ifc.M_AXI_AWADDR;
                end
                if (ifc.M_AXI_WVALID && ifc.M_AXI_WREADY) begin
                    got_w <= 1'b1;
                    w_d   <= ifc.M_AXI_WDATA;
                    w_s   <= ifc.M_AXI_WSTRB;
                end
            end
            if (b_pend && ifc.M_AXI_BREADY) b_pend <= 1'b0;
            if (ifc.M_AXI_ARVALID && ifc.M_AXI_ARREADY) begin
                r_pend <= 1'b1;
                r_cnt  <= r_dly;
                r_d    <= ovr_en ? ovr_data : mem[ifc.M_AXI_ARADDR[5:2]];
            end else if (r_pend && r_cnt != 0) begin
                r_cnt <= r_cnt - 1;
            end
            if (r_pend && r_cnt == 0 && ifc.M_AXI_RREADY) r_pend <= 1'b0;
        end
    end

    // Bus monitor: cumulative counters sampled mid-cycle.
    int          cyc, aw_hi, w_hi, ar_hi, hs_b, hs_r, rsp_cnt, addr_bad;
    logic [5:0]  mon_addr;
    logic [31:0] mon_wdata;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (ifc.M_AXI_AWVALID) aw_hi <= aw_hi + 1;
        if (ifc.M_AXI_WVALID)  w_hi  <= w_hi + 1;
        if (ifc.M_AXI_ARVALID) ar_hi <= ar_hi + 1;
        if (ifc.M_AXI_BVALID && ifc.M_AXI_BREADY) hs_b <= hs_b + 1;
        if (ifc.M_AXI_RVALID && ifc.M_AXI_RREADY) hs_r <= hs_r + 1;
        if (rsp_valid) rsp_cnt <= rsp_cnt + 1;
        if ((ifc.M_AXI_AWVALID && ifc.M_AXI_AWADDR != mon_addr)
                || (ifc.M_AXI_ARVALID && ifc.M_AXI_ARADDR != mon_addr)
                || (ifc.M_AXI_WVALID && ifc.M_AXI_WDATA != mon_wdata))
            addr_bad <= addr_bad + 1;
    end

    initial begin
        cyc = 0; aw_hi = 0; w_hi = 0; ar_hi = 0; hs_b = 0; hs_r = 0; rsp_cnt = 0; addr_bad = 0;
    end

    int checks, errors;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Issue one command starting at a negedge; returns at the negedge after the response pulse.
    task automatic do_cmd(input logic wr, input logic [5:0] a, input logic [31:0] d, input logic [3:0] s,
                          output logic [31:0] rd, output logic [1:0] rs, output int lat, output int hs_cyc,
                          output logic rdy_bad, output logic pulse_bad, output logic hold_bad, output logic ok);
        int n;
        mon_addr  = a;
        mon_wdata = d;
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
        n = 0;
        while (!cmd_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        hs_cyc = cyc;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        lat = 0; ok = 1'b0; rdy_bad = 1'b0; rd = '0; rs = '0;
        while (lat < 100 && !ok) begin
            @(negedge clk);
            lat++;
            if (cmd_ready) rdy_bad = 1'b1;
            if (rsp_valid) begin
                ok = 1'b1;
                rd = rsp_rdata;
                rs = rsp_resp;
            end
        end
        @(negedge clk);
        pulse_bad = rsp_valid;
        hold_bad  = (rsp_rdata !== rd) || (rsp_resp !== rs);
    endtask

    typedef struct {
        logic        wr;
        logic [5:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        int          aw_d, w_d, ar_d, r_d;
        logic [1:0]  sresp;
        logic        oen;
        logic [31:0] odata;
        logic [31:0] exp_rdata;
        logic [1:0]  exp_resp;
        int          exp_lat, exp_aw, exp_w, exp_ar;
    } vec_t;

    vec_t vt [11];

    initial begin
        logic [31:0] rd, wdat;
        logic [1:0]  rs;
        int          lat, c0, c1, a0, w0, r0, b0, hr0, rc0, ab0, bad_rd, bad_rdy, bad_per;
        logic        rdy_bad, pulse_bad, hold_bad, ok;

        vt[0]  = '{1'b1, 6'h04, 32'hDEADBEEF, 4'hF, 0, 0, 0, 0, 2'b00, 1'b0, 32'h0, 32'h0,        2'b00, 3, 1, 1, 0};
        vt[1]  = '{1'b0, 6'h04, 32'h0,        4'h0, 0, 0, 0, 0, 2'b00, 1'b0, 32'h0, 32'hDEADBEEF, 2'b00, 3, 0, 0, 1};
        vt[2]  = '{1'b1, 6'h08, 32'h11223344, 4'h5, 3, 0, 0, 0, 2'b00, 1'b0, 32'h0, 32'h0,        2'b00, 6, 4, 1, 0};
        vt[3]  = '{1'b0, 6'h08, 32'h0,        4'h0, 0, 0, 0, 0, 2'b00, 1'b0, 32'h0, 32'h00220044, 2'b00, 3, 0, 0, 1};
        vt[4]  = '{1'b1, 6'h0C, 32'hCAFEF00D, 4'hF, 0, 2, 0, 0, 2'b01, 1'b0, 32'h0, 32'h0,        2'b01, 5, 1, 3, 0};
        vt[5]  = '{1'b0, 6'h0C, 32'h0,        4'h0, 0, 0, 2, 1, 2'b00, 1'b0, 32'h0, 32'hCAFEF00D, 2'b00, 6, 0, 0, 3};
        vt[6]  = '{1'b0, 6'h10, 32'h0,        4'h0, 0, 0, 0, 0, 2'b10, 1'b1, 32'h12345678, 32'h12345678, 2'b10, 3, 0, 0, 1};
        vt[7]  = '{1'b1, 6'h3C, 32'hA5A55A5A, 4'hF, 2, 2, 0, 0, 2'b00, 1'b0, 32'h0, 32'h0,        2'b00, 5, 3, 3, 0};
        vt[8]  = '{1'b0, 6'h3C, 32'h0,        4'h0, 0, 0, 0, 0, 2'b00, 1'b0, 32'h0, 32'hA5A55A5A, 2'b00, 3, 0, 0, 1};
        vt[9]  = '{1'b1, 6'h3C, 32'h00000000, 4'h8, 0, 1, 0, 0, 2'b11, 1'b0, 32'h0, 32'h0,        2'b11, 4, 1, 2, 0};
        vt[10] = '{1'b0, 6'h3C, 32'h0,        4'h0, 0, 0, 0, 2, 2'b00, 1'b0, 32'h0, 32'h00A55A5A, 2'b00, 5, 0, 0, 1};

        checks = 0; errors = 0;
        aw_dly = 0; w_dly = 0; ar_dly = 0; r_dly = 0;
        slv_resp = 2'b00; ovr_en = 1'b0; ovr_data = '0; spur = 1'b0;
        mon_addr = '0; mon_wdata = '0;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
        rst_n = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst cmd_ready", 64'(cmd_ready), 64'd0);
        chk("rst valids", 64'({ifc.M_AXI_AWVALID, ifc.M_AXI_WVALID, ifc.M_AXI_BREADY,
                              ifc.M_AXI_ARVALID, ifc.M_AXI_RREADY}), 64'd0);
        chk("rst rsp", 64'({rsp_valid, rsp_resp, rsp_rdata}), 64'd0);
        chk("rst addr/data", 64'({ifc.M_AXI_AWADDR, ifc.M_AXI_WDATA, ifc.M_AXI_WSTRB}), 64'd0);
        chk("prot", 64'({ifc.M_AXI_AWPROT, ifc.M_AXI_ARPROT}), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle cmd_ready", 64'(cmd_ready), 64'd1);

        // Table-driven transactions
        for (int i = 0; i < 11; i++) begin
            aw_dly = vt[i].aw_d; w_dly = vt[i].w_d; ar_dly = vt[i].ar_d; r_dly = vt[i].r_d;
            slv_resp = vt[i].sresp; ovr_en = vt[i].oen; ovr_data = vt[i].odata;
            a0 = aw_hi; w0 = w_hi; r0 = ar_hi; b0 = hs_b; hr0 = hs_r; rc0 = rsp_cnt; ab0 = addr_bad;
            do_cmd(vt[i].wr, vt[i].addr, vt[i].wdata, vt[i].strb, rd, rs, lat, c0, rdy_bad, pulse_bad, hold_bad, ok);
            #1;
            chk($sformatf("v%0d completed", i), 64'(ok), 64'd1);
            chk($sformatf("v%0d rsp_rdata", i), 64'(rd), 64'(vt[i].exp_rdata));
            chk($sformatf("v%0d rsp_resp", i), 64'(rs), 64'(vt[i].exp_resp));
            chk($sformatf("v%0d latency", i), 64'(lat), 64'(vt[i].exp_lat));
            chk($sformatf("v%0d cmd_ready busy", i), 64'(rdy_bad), 64'd0);
            chk($sformatf("v%0d rsp pulse width", i), 64'(pulse_bad), 64'd0);
            chk($sformatf("v%0d rsp hold", i), 64'(hold_bad), 64'd0);
            chk($sformatf("v%0d awvalid cycles", i), 64'(aw_hi - a0), 64'(vt[i].exp_aw));
            chk($sformatf("v%0d wvalid cycles", i), 64'(w_hi - w0), 64'(vt[i].exp_w));
            chk($sformatf("v%0d arvalid cycles", i), 64'(ar_hi - r0), 64'(vt[i].exp_ar));
            chk($sformatf("v%0d b/r handshakes", i), 64'({32'(hs_b - b0), 32'(hs_r - hr0)}),
                64'({32'(vt[i].wr ? 1 : 0), 32'(vt[i].wr ? 0 : 1)}));
            chk($sformatf("v%0d rsp count", i), 64'(rsp_cnt - rc0), 64'd1);
            chk($sformatf("v%0d addr/data stable", i), 64'(addr_bad - ab0), 64'd0);
        end
        aw_dly = 0; w_dly = 0; ar_dly = 0; r_dly = 0; slv_resp = 2'b00; ovr_en = 1'b0;

        // Spurious BVALID/RVALID while idle
        rc0 = rsp_cnt;
        spur = 1'b1;
        c1 = 0;
        repeat (3) begin
            @(negedge clk);
            if (ifc.M_AXI_BREADY || ifc.M_AXI_RREADY) c1++;
        end
        spur = 1'b0;
        @(negedge clk);
        #1;
        chk("spurious ready", 64'(c1), 64'd0);
        chk("spurious rsp", 64'(rsp_cnt - rc0), 64'd0);
        chk("spurious idle", 64'(cmd_ready), 64'd1);

        // Random write/read pairs to address 0, back to back
        bad_rd = 0; bad_rdy = 0; bad_per = 0;
        for (int k = 0; k < 200; k++) begin
            wdat = $urandom;
            do_cmd(1'b1, 6'h00, wdat, 4'hF, rd, rs, lat, c0, rdy_bad, pulse_bad, hold_bad, ok);
            if (rdy_bad || !ok || rs != 2'b00) bad_rdy++;
            do_cmd(1'b0, 6'h00, 32'h0, 4'h0, rd, rs, lat, c1, rdy_bad, pulse_bad, hold_bad, ok);
            if (rdy_bad || !ok || rs != 2'b00) bad_rdy++;
            if (c1 - c0 != 4) bad_per++;
            if (rd !== wdat) begin
                bad_rd++;
                if (bad_rd < 4) chk($sformatf("rand pair %0d rdata", k), 64'(rd), 64'(wdat));
            end
        end
        chk("rand read mismatches", 64'(bad_rd), 64'd0);
        chk("rand busy/resp errors", 64'(bad_rdy), 64'd0);
        chk("rand period not 4", 64'(bad_per), 64'd0);

`ifdef AXI_MASTER_TIMEOUT_EN
        // Watchdog: AR never accepted
        ar_dly = 100000;
        r0 = ar_hi;
        do_cmd(1'b0, 6'h04, 32'h0, 4'h0, rd, rs, lat, c0, rdy_bad, pulse_bad, hold_bad, ok);
        #1;
        chk("to completed", 64'(ok), 64'd1);
        chk("to arvalid cycles", 64'(ar_hi - r0), 64'd16);
        chk("to latency", 64'(lat), 64'd17);
        chk("to rsp", 64'({rs, rd}), 64'({2'b10, 32'h0}));
        chk("to back idle", 64'(cmd_ready), 64'd1);
        ar_dly = 0;
`endif

        // Reset pulsed in the middle of a read
        ar_dly = 5;
        rc0 = rsp_cnt;
        mon_addr = 6'h04;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 6'h04;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        @(negedge clk);
        chk("midrst arvalid before", 64'(ifc.M_AXI_ARVALID), 64'd1);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("midrst valids", 64'({ifc.M_AXI_AWVALID, ifc.M_AXI_WVALID, ifc.M_AXI_BREADY,
                                 ifc.M_AXI_ARVALID, ifc.M_AXI_RREADY}), 64'd0);
        chk("midrst rsp_valid", 64'(rsp_valid), 64'd0);
        chk("midrst cmd_ready", 64'(cmd_ready), 64'd0);
        ar_dly = 0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        #1;
        chk("midrst no rsp", 64'(rsp_cnt - rc0), 64'd0);
        chk("midrst idle", 64'(cmd_ready), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/axi4lite_master.md
Name: axi4lite_master

Overview:
- AXI4-Lite initiator that converts a simple single-beat command interface into AXI4-Lite write and read transactions.
- Drives the register-file slave (tx_req/tx_done control, perf counters) from on-chip control logic instead of the host.
- One outstanding transaction at a time.
- Reports read data and response code back on a response strobe.

Parameters:
- AXIS_DATA_WIDTH, 32, data bus width; must be 32 or 64.
- AXIS_ADDR_WIDTH, 6, byte address width.
- TIMEOUT_CYCLES, 1024, watchdog limit in cycles; used only with AXI_MASTER_TIMEOUT_EN.

Ports:
- M_AXI_ACLK  in  1  clock
- M_AXI_ARESETN  in  1  asynchronous active-low reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  command accepted when cmd_valid&&cmd_ready
- cmd_write  in  1  1=write, 0=read
- cmd_addr  in  AXIS_ADDR_WIDTH  byte address
- cmd_wdata  in  AXIS_DATA_WIDTH  write data
- cmd_wstrb  in  AXIS_DATA_WIDTH/8  write byte strobes
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  AXIS_DATA_WIDTH  read data; 0 for writes
- rsp_resp  out  2  BRESP/RRESP; 2'b10 on timeout
- M_AXI_AWADDR  out  AXIS_ADDR_WIDTH
- M_AXI_AWPROT  out  3  constant 3'b000
- M_AXI_AWVALID  out  1
- M_AXI_AWREADY  in  1
- M_AXI_WDATA  out  AXIS_DATA_WIDTH
- M_AXI_WSTRB  out  AXIS_DATA_WIDTH/8
- M_AXI_WVALID  out  1
- M_AXI_WREADY  in  1
- M_AXI_BRESP  in  2
- M_AXI_BVALID  in  1
- M_AXI_BREADY  out  1
- M_AXI_ARADDR  out  AXIS_ADDR_WIDTH
- M_AXI_ARPROT  out  3  constant 3'b000
- M_AXI_ARVALID  out  1
- M_AXI_ARREADY  in  1
- M_AXI_RDATA  in  AXIS_DATA_WIDTH
- M_AXI_RRESP  in  2
- M_AXI_RVALID  in  1
- M_AXI_RREADY  out  1

Behaviour:
- Clock and reset: single clock domain. Reset is asynchronous assert, active-low; all flops are released synchronously on M_AXI_ACLK.
- Reset values: all VALID/READY outputs 0, rsp_valid 0, rsp_rdata 0, rsp_resp 0, address/data registers 0, FSM in IDLE, cmd_ready 0.
- cmd_ready = (state==IDLE) && M_AXI_ARESETN, combinational from state.
- FSM states: IDLE, WR, WR_RESP, RD_ADDR, RD_DATA, DONE.
- IDLE: on a command handshake, address, data and strobe are registered. Go to WR (AWVALID=1, WVALID=1 next cycle) or RD_ADDR (ARVALID=1 next cycle).
- WR: AWVALID and WVALID are tracked independently. Each drops the cycle after its own handshake and never re-asserts within the transaction. Leave WR once both handshakes are done, including both in the same cycle. BREADY is asserted on entry to WR_RESP.
- WR_RESP: BREADY=1 until BVALID. On the handshake, capture BRESP, drop BREADY, go to DONE.
- RD_ADDR: ARVALID=1 until ARREADY, then ARVALID=0, RREADY=1, go to RD_DATA.
- RD_DATA: on RVALID, capture RDATA/RRESP, drop RREADY, go to DONE.
- DONE: rsp_valid=1 for exactly one cycle, then IDLE. rsp_rdata/rsp_resp hold until the next completion.
- Latency with an always-ready slave:
  - write: cmd handshake at cycle 0, AW/W handshake at cycle 1, B handshake at cycle 2, rsp_valid at cycle 3.
  - read: AR handshake at cycle 1, R handshake at cycle 2, rsp_valid at cycle 3.
- Address, data and strobe outputs are stable while the corresponding VALID is high; AXI rule: VALID never depends on READY.
- Early or spurious responses: BVALID/RVALID arriving outside WR_RESP/RD_DATA are ignored, since READY is low.
- Back-to-back commands: next cmd_ready is the cycle after rsp_valid, giving a minimum 4-cycle transaction period.
- Reset mid-transaction: all VALID/READY outputs drop asynchronously and the transaction is abandoned without a response.

Optional Feature:
- Macro: AXI_MASTER_TIMEOUT_EN.
- When defined: a counter of width $clog2(TIMEOUT_CYCLES+1) runs in every non-IDLE, non-DONE state and resets on each state transition. When the count reaches TIMEOUT_CYCLES-1, all VALID/READY outputs are dropped, rsp_resp=2'b10 (SLVERR) and rsp_rdata=0, and the FSM goes to DONE. A handshake in the same cycle as expiry takes priority over the timeout.
- When undefined: no counter; the FSM waits indefinitely.

Test Plan:
- Always-ready slave, write addr 0x04 data 0xDEADBEEF strb 0xF → AW/W handshake at cycle 1, BREADY at cycle 2, rsp_valid at cycle 3 with rsp_resp=0.
- Read addr 0x04 after that write against the axi4lite_slave register file → rsp_rdata=0xDEADBEEF, rsp_resp=0, rsp_valid pulse exactly 1 cycle.
- AWREADY delayed 3 cycles, WREADY immediate → WVALID drops after 1 cycle, AWVALID held 4 cycles with AWADDR stable, single B handshake, one rsp_valid.
- Slave returns RRESP=2'b10 with RDATA=0x12345678 → rsp_resp=2'b10, rsp_rdata=0x12345678.
- 200 random write/read pairs to addr 0 → every read matches the preceding write; cmd_ready low throughout each transaction.
- With AXI_MASTER_TIMEOUT_EN and TIMEOUT_CYCLES=16, ARREADY tied 0 → ARVALID drops after 16 cycles, rsp_resp=2'b10, FSM back in IDLE. Separately, ARESETN pulsed low mid-read → all VALID/READY 0 immediately, no rsp_valid.
